// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: state encoding and shared widths for the PLL reset supervisor
package pll_rst_pkg;
  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAITLOCK = 3'd1,
    S_STABLE   = 3'd2,
    S_RUN      = 3'd3,
    S_FAIL     = 3'd4
  } state_t;
  localparam int RETRY_W = 4;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with asynchronous active-high reset
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/pll_rst_ctrl.sv
// pll_rst_ctrl: sequences PLL reset, lock qualification and system reset release
module pll_rst_ctrl
  import pll_rst_pkg::*;
#(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               fail,
  output logic               lost_lock,
  output logic [RETRY_W-1:0] retry_cnt
);
  localparam int CNT_MAX = max3(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] RP_END = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] LT_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SC_END = CW'(STABLE_CYCLES - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic locked_s, att_fail, give_up;
  logic [RETRY_W-1:0] retry_inc;
  sync_2ff #(.W(1)) u_sync (
    .clk(clkin),
    .rst(rst),
    .d  (pll_locked),
    .q  (locked_s)
  );
  always_comb begin
    att_fail  = !locked_s && (state == S_STABLE || (state == S_WAITLOCK && cnt == LT_END));
    retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;
    give_up   = (MAX_RETRY != 0) && (retry_inc == RETRY_W'(MAX_RETRY));
  end
  always_ff @(posedge clkin or posedge rst)
    if (rst) begin
      state     <= S_PLLRST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      fail      <= 1'b0;
      lost_lock <= 1'b0;
    end else if (att_fail) begin
      state     <= give_up ? S_FAIL : S_PLLRST;
      cnt       <= '0;
      retry_cnt <= retry_inc;
      pll_rst   <= 1'b1;
      fail      <= give_up;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        S_PLLRST:
          if (cnt == RP_END) begin
            state   <= S_WAITLOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end
        S_WAITLOCK:
          if (locked_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end
        S_STABLE:
          if (cnt == SC_END) begin
            state     <= S_RUN;
            cnt       <= '0;
            retry_cnt <= '0;
            sys_rst   <= 1'b0;
          end
        S_RUN:
          if (!locked_s) begin
            state     <= S_PLLRST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            lost_lock <= 1'b1;
          end else if (sw_rst_req) begin
            // re-qualify through WAITLOCK so soft reset lasts STABLE_CYCLES+1, like a cold lock
            state   <= S_WAITLOCK;
            cnt     <= '0;
            sys_rst <= 1'b1;
          end
        S_FAIL:
          if (sw_rst_req) begin
            state     <= S_PLLRST;
            cnt       <= '0;
            retry_cnt <= '0;
            fail      <= 1'b0;
          end
        default: begin
          state   <= S_PLLRST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
        end
      endcase
    end
endmodule
